// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: checks alignment, holds a fixed-latency
// memory access, then returns extended load data or a completion over valid/ready.
module lsu_mem_initiator #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;

    logic        misalign;
    logic [3:0]  base;
    logic [31:0] lane;
    logic [31:0] ext;

    always_comb begin
        misalign = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);
        case (req_size)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        lane = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
            2'd1:    ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_valid_d  = mem_valid_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    resp_rdata_d = 32'h0;
                    if (misalign) begin
                        state_d    = RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        resp_err_d  = 1'b0;
                        cnt_d       = 4'(MEM_LAT - 1);
                        off_d       = req_addr[1:0];
                        size_d      = req_size;
                        uns_d       = req_unsigned;
                        mem_valid_d = 1'b1;
                        mem_wen_d   = req_wen;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        // loads drive neither data nor mask
                        mem_wdata_d = req_wen ? (req_wdata << {req_addr[1:0], 3'b000}) : 32'h0;
                        mem_wmask_d = req_wen ? (base << req_addr[1:0]) : 4'h0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_rdata_d = mem_wen_q ? 32'h0 : ext;
                    resp_err_d   = 1'b0;
                    mem_valid_d  = 1'b0;
                    mem_wen_d    = 1'b0;
                    mem_addr_d   = 32'h0;
                    mem_wdata_d  = 32'h0;
                    mem_wmask_d  = 4'h0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wmask_q  <= 4'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_valid_q  <= mem_valid_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_valid  = mem_valid_q;
    assign mem_wen    = mem_wen_q;
    assign mem_raddr  = mem_addr_q;
    assign mem_waddr  = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = {4'b0000, mem_wmask_q};

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench: one instance with MEM_LAT=1 and one with MEM_LAT=4, each with a small byte-masked memory.
module tb_lsu_mem_initiator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid1, req_valid4, req_wen, req_unsigned, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_ready1, resp_valid1, resp_err1, mem_valid1, mem_wen1;
    logic [31:0] resp_rdata1, mem_raddr1, mem_waddr1, mem_wdata1, mem_rdata1;
    logic [7:0]  mem_wmask1;
    logic        req_ready4, resp_valid4, resp_err4, mem_valid4, mem_wen4;
    logic [31:0] resp_rdata4, mem_raddr4, mem_waddr4, mem_wdata4, mem_rdata4;
    logic [7:0]  mem_wmask4;

    lsu_mem_initiator #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .mem_valid(mem_valid1), .mem_wen(mem_wen1),
        .mem_raddr(mem_raddr1), .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1),
        .mem_wmask(mem_wmask1), .mem_rdata(mem_rdata1));

    lsu_mem_initiator #(.MEM_LAT(4)) u_lat4 (
        .clk(clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid4), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata4), .resp_err(resp_err4), .mem_valid(mem_valid4), .mem_wen(mem_wen4),
        .mem_raddr(mem_raddr4), .mem_waddr(mem_waddr4), .mem_wdata(mem_wdata4),
        .mem_wmask(mem_wmask4), .mem_rdata(mem_rdata4));

    logic [31:0] mem1 [16];
    logic [31:0] mem4 [16];
    assign mem_rdata1 = mem1[mem_raddr1[5:2]];
    assign mem_rdata4 = mem4[mem_raddr4[5:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_valid1 && mem_wen1 && mem_wmask1[b]) mem1[mem_waddr1[5:2]][8*b +: 8] <= mem_wdata1[8*b +: 8];
            if (mem_valid4 && mem_wen4 && mem_wmask4[b]) mem4[mem_waddr4[5:2]][8*b +: 8] <= mem_wdata4[8*b +: 8];
        end
    end

    logic        sel;
    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_valid;
    logic [31:0] o_resp_rdata, o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    assign o_req_ready  = sel ? req_ready4  : req_ready1;
    assign o_resp_valid = sel ? resp_valid4 : resp_valid1;
    assign o_resp_err   = sel ? resp_err4   : resp_err1;
    assign o_mem_valid  = sel ? mem_valid4  : mem_valid1;
    assign o_resp_rdata = sel ? resp_rdata4 : resp_rdata1;
    assign o_mem_wdata  = sel ? mem_wdata4  : mem_wdata1;
    assign o_mem_wmask  = sel ? mem_wmask4  : mem_wmask1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure accept-to-resp_valid latency and mem_valid cycles.
    task automatic txn(input string tag, input logic s, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                       input int exp_mv, input logic [7:0] exp_mask, input logic [31:0] exp_wdata);
        int n, mv;
        logic seen;
        logic [7:0] mask;
        logic [31:0] wd;
        sel = s;
        @(negedge clk);
        req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
        if (s) req_valid4 = 1'b1; else req_valid1 = 1'b1;
        chk({tag, " req_ready"}, {31'b0, o_req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid1 = 1'b0; req_valid4 = 1'b0;
        n = 0; mv = 0; seen = 1'b0; mask = 8'h0; wd = 32'h0;
        do begin
            @(negedge clk);
            n++;
            if (o_mem_valid) begin
                mv++;
                if (!seen) begin mask = o_mem_wmask; wd = o_mem_wdata; seen = 1'b1; end
            end
        end while (!o_resp_valid && n < 40);
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " mem_valid cycles"}, mv, exp_mv);
        chk({tag, " resp_rdata"}, o_resp_rdata, exp_rdata);
        chk({tag, " resp_err"}, {31'b0, o_resp_err}, {31'b0, exp_err});
        if (exp_mv != 0) begin
            chk({tag, " wmask"}, {24'b0, mask}, {24'b0, exp_mask});
            chk({tag, " wdata"}, wd, exp_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, " ready after"}, {31'b0, o_req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; sel = 1'b0;
        req_valid1 = 1'b0; req_valid4 = 1'b0; req_wen = 1'b0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'd0; resp_ready = 1'b1;
        #12;
        chk("rst req_ready",  {31'b0, req_ready1}, 32'd1);
        chk("rst resp_valid", {31'b0, resp_valid1 | resp_valid4}, 32'd0);
        chk("rst mem_valid",  {31'b0, mem_valid1 | mem_valid4 | mem_wen1}, 32'd0);
        chk("rst resp_rdata", resp_rdata1 | resp_rdata4, 32'd0);
        chk("rst mem bus",    mem_raddr1 | mem_wdata1 | {24'b0, mem_wmask1}, 32'd0);
        @(negedge clk) reset = 1'b0;

        // MEM_LAT=1
        txn("sw",   1'b0, 1'b1, 32'h80000004, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0, 2, 1, 8'h0F, 32'hDEADBEEF);
        txn("lw",   1'b0, 1'b0, 32'h80000004, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1, 8'h00, 32'h0);
        txn("sw0",  1'b0, 1'b1, 32'h80000000, 32'h80FF7F01, 2'd2, 1'b0, 32'h0, 1'b0, 2, 1, 8'h0F, 32'h80FF7F01);
        txn("lb",   1'b0, 1'b0, 32'h80000003, 32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 1'b0, 2, 1, 8'h00, 32'h0);
        txn("lbu",  1'b0, 1'b0, 32'h80000003, 32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0, 2, 1, 8'h00, 32'h0);
        txn("lh",   1'b0, 1'b0, 32'h80000002, 32'h0,        2'd1, 1'b0, 32'hFFFF80FF, 1'b0, 2, 1, 8'h00, 32'h0);
        txn("lbu1", 1'b0, 1'b0, 32'h80000001, 32'h0,        2'd0, 1'b1, 32'h0000007F, 1'b0, 2, 1, 8'h00, 32'h0);
        txn("sb",   1'b0, 1'b1, 32'h80000002, 32'h000000AB, 2'd0, 1'b0, 32'h0, 1'b0, 2, 1, 8'h04, 32'h00AB0000);
        txn("lw sb", 1'b0, 1'b0, 32'h80000000, 32'h0,       2'd2, 1'b0, 32'h80AB7F01, 1'b0, 2, 1, 8'h00, 32'h0);
        txn("sh hi", 1'b0, 1'b1, 32'h80000006, 32'h00001234, 2'd1, 1'b0, 32'h0, 1'b0, 2, 1, 8'h0C, 32'h12340000);
        txn("mis lw", 1'b0, 1'b0, 32'h80000002, 32'h0,      2'd2, 1'b0, 32'h0, 1'b1, 1, 0, 8'h00, 32'h0);
        txn("mis sh", 1'b0, 1'b1, 32'h80000001, 32'h5555,   2'd1, 1'b0, 32'h0, 1'b1, 1, 0, 8'h00, 32'h0);
        txn("size3",  1'b0, 1'b0, 32'h80000000, 32'h0,      2'd3, 1'b0, 32'h0, 1'b1, 1, 0, 8'h00, 32'h0);
        txn("lw after mis", 1'b0, 1'b0, 32'h80000004, 32'h0, 2'd2, 1'b0, 32'h1234BEEF, 1'b0, 2, 1, 8'h00, 32'h0);

        // MEM_LAT=4
        txn("sw4",  1'b1, 1'b1, 32'h80000008, 32'h12345678, 2'd2, 1'b0, 32'h0, 1'b0, 5, 4, 8'h0F, 32'h12345678);
        txn("lhu4", 1'b1, 1'b0, 32'h8000000A, 32'h0,        2'd1, 1'b1, 32'h00001234, 1'b0, 5, 4, 8'h00, 32'h0);

        // back-pressure with a competing request
        sel = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        req_wen = 1'b0; req_addr = 32'h80000008; req_size = 2'd2; req_unsigned = 1'b0; req_valid4 = 1'b1;
        @(posedge clk);
        #1 req_valid4 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid4 && n < 40);
        chk("bp latency", n, 5);
        req_addr = 32'h8000000C; req_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp resp_valid", {31'b0, resp_valid4}, 32'd1);
            chk("bp resp_rdata", resp_rdata4, 32'h12345678);
            chk("bp req_ready",  {31'b0, req_ready4}, 32'd0);
            chk("bp mem_valid",  {31'b0, mem_valid4}, 32'd0);
        end
        req_valid4 = 1'b0; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp ready after", {31'b0, req_ready4}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp no 2nd req", {31'b0, mem_valid4 | resp_valid4}, 32'd0);
        end

        // reset in the 2nd ACCESS cycle
        @(negedge clk);
        req_wen = 1'b0; req_addr = 32'h80000008; req_size = 2'd2; req_valid4 = 1'b1;
        @(posedge clk);
        #1 req_valid4 = 1'b0;
        @(posedge clk);
        #1 chk("rst mid mem_valid before", {31'b0, mem_valid4}, 32'd1);
        reset = 1'b1;
        #1 chk("rst mid mem_valid async", {31'b0, mem_valid4}, 32'd0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst mid no resp", {31'b0, resp_valid4 | mem_valid4}, 32'd0);
        end
        chk("rst mid req_ready", {31'b0, req_ready4}, 32'd1);
        txn("lw4 post rst", 1'b1, 1'b0, 32'h80000008, 32'h0, 2'd2, 1'b0, 32'h12345678, 1'b0, 5, 4, 8'h00, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
